// File: rtl/pwm_decoder_if.sv
// Purpose: bundles the four raw PWM pins and the decoded width/strobe/lost outputs.
// Latency: none, wiring only.
// Backpressure: none; results are strobed and the consumer must take them in that cycle.
interface pwm_decoder_if;
  // Raw receiver pins, asynchronous to clk
  logic [3:0]  pwm_in;
  // Last accepted width minus OFFSET, per channel
  logic [11:0] val [0:3];
  // One-cycle strobe: val[i] was updated this cycle
  logic [3:0]  valid;
  // Channel has had no accepted pulse recently (or ever since reset)
  logic [3:0]  lost;

  // Side that drives the pins and consumes decoded widths
  modport master (
    output pwm_in,
    input  val,
    input  valid,
    input  lost
  );

  // The decoder itself
  modport slave (
    input  pwm_in,
    output val,
    output valid,
    output lost
  );
endinterface

// File: rtl/pwm_decoder.sv
// Purpose: four-channel RC PWM high-time decoder with glitch/overlength rejection and loss detect.
// Latency: val/valid update 3 clk edges after the first edge that samples the pin low.
// Backpressure: none; valid is a one-cycle strobe, val holds until the next accepted pulse.
module pwm_decoder #(
  parameter int OFFSET    = 1000,
  parameter int MIN_WIDTH = 500,
  parameter int MAX_WIDTH = 2500,
  parameter int TIMEOUT   = 25000
) (
  input  logic         clk,
  input  logic         rst,
  pwm_decoder_if.slave bus
);

  localparam int SW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] WAIT_LOW  = 2'd0;
  localparam logic [1:0] WAIT_RISE = 2'd1;
  localparam logic [1:0] MEASURE   = 2'd2;

  localparam logic [11:0]   MIN_V = 12'(MIN_WIDTH);
  localparam logic [11:0]   MAX_V = 12'(MAX_WIDTH);
  localparam logic [12:0]   OFF_V = 13'(OFFSET);
  localparam logic [SW-1:0] TO_V  = SW'(TIMEOUT);

  logic [11:0] val_v [0:3];
  logic [3:0]  valid_v;
  logic [3:0]  lost_v;

  // The synchronizers come out of reset holding 0, which would look like a
  // genuine low level on a pin that is actually mid-pulse. Until s2 carries a
  // real pin sample, WAIT_LOW must not trust it, otherwise the tail of a pulse
  // in progress at reset release would be measured as a complete pulse.
  logic [1:0] arm;
  logic       armed;

  // Count the two edges needed to flush reset zeros out of s1/s2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm <= 2'd0;
    end else if (arm != 2'd2) begin
      arm <= arm + 2'd1;
    end
  end

  assign armed = (arm == 2'd2);

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_ch
      logic          s1, s2, s3;
      logic          rise, fall;
      logic [1:0]    state;
      logic [11:0]   cnt;
      logic          pend;
      logic [11:0]   pend_w;
      logic [11:0]   val_q;
      logic          valid_q;
      logic [SW-1:0] sil;
      logic          seen;

      // Bring the asynchronous pin into the clk domain; s3 is the edge-detect history
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s1 <= 1'b0;
          s2 <= 1'b0;
          s3 <= 1'b0;
        end else begin
          s1 <= bus.pwm_in[i];
          s2 <= s1;
          s3 <= s2;
        end
      end

      assign rise = s2 & ~s3;
      assign fall = ~s2 & s3;

      // Pulse measurement FSM; pend flags an in-range width for the output stage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state  <= WAIT_LOW;
          cnt    <= 12'd0;
          pend   <= 1'b0;
          pend_w <= 12'd0;
        end else begin
          pend <= 1'b0;
          case (state)
            WAIT_LOW: begin
              if (armed && !s2) begin
                state <= WAIT_RISE;
              end
            end
            WAIT_RISE: begin
              if (rise) begin
                cnt   <= 12'd1;
                state <= MEASURE;
              end
            end
            MEASURE: begin
              if (fall) begin
                // cnt already equals the number of edges that sampled the pin high
                state <= WAIT_RISE;
                if (cnt >= MIN_V && cnt <= MAX_V) begin
                  pend   <= 1'b1;
                  pend_w <= cnt;
                end
              end else if (s2) begin
                // Overlength: abandon before cnt can pass MAX_WIDTH, and wait
                // for the pin to drop so the remainder is not measured
                if (cnt >= MAX_V) begin
                  state <= WAIT_LOW;
                end else begin
                  cnt <= cnt + 12'd1;
                end
              end
            end
            default: begin
              state <= WAIT_LOW;
            end
          endcase
        end
      end

      // Convert an accepted width to an offset value, clamping below OFFSET to 0
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          val_q   <= 12'd0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= pend;
          if (pend) begin
            if ({1'b0, pend_w} < OFF_V) begin
              val_q <= 12'd0;
            end else begin
              val_q <= 12'({1'b0, pend_w} - OFF_V);
            end
          end
        end
      end

      // Silence counter: cleared on the same edge valid rises, else saturates at TIMEOUT
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sil  <= '0;
          seen <= 1'b0;
        end else if (pend) begin
          sil  <= '0;
          seen <= 1'b1;
        end else if (sil != TO_V) begin
          sil <= sil + 1'b1;
        end
      end

      assign val_v[i]   = val_q;
      assign valid_v[i] = valid_q;
      assign lost_v[i]  = !seen || (sil == TO_V);
    end
  endgenerate

  assign bus.val   = val_v;
  assign bus.valid = valid_v;
  assign bus.lost  = lost_v;

endmodule
